// File: rtl/crash_sequencer_pkg.sv
// Shared game package for the crash sequencer slice.
// Holds the player state encoding and the default frame/lives constants
// used as parameter defaults by crash_sequencer.
package crash_sequencer_pkg;

  // Legacy-compatible state encodings; the enum below reuses them so
  // existing code comparing against raw 2-bit values keeps working.
  localparam logic [1:0] S_NORMAL    = 2'd0;
  localparam logic [1:0] S_CRASH     = 2'd1;
  localparam logic [1:0] S_RESPAWN   = 2'd2;
  localparam logic [1:0] S_GAME_OVER = 2'd3;

  typedef enum logic [1:0] {
    ST_NORMAL    = S_NORMAL,
    ST_CRASH     = S_CRASH,
    ST_RESPAWN   = S_RESPAWN,
    ST_GAME_OVER = S_GAME_OVER
  } state_e;

  localparam int unsigned DEF_CRASH_FRAMES   = 60;
  localparam int unsigned DEF_RESPAWN_FRAMES = 90;
  localparam int unsigned DEF_BLINK_HALF     = 4;
  localparam int unsigned DEF_INIT_LIVES     = 3;

endpackage

// File: rtl/crash_sequencer_if.sv
// Game-logic bus between the frame/collision front end and the crash
// sequencer.
//   frame_start    : one-clk pulse per video frame
//   collisions     : [0] player/AI-car hit, [1] player/fuel-can hit
//   restart        : one-clk new-game request
//   state, lives   : current player state and remaining lives
//   speed_zero, steer_enable, player_visible, fuel_refill, game_over
//                  : player control / draw / refill outputs
// master drives the requests, slave (the sequencer) drives the status.
interface crash_sequencer_if;
  logic       frame_start;
  logic [1:0] collisions;
  logic       restart;
  logic [1:0] state;
  logic [1:0] lives;
  logic       speed_zero;
  logic       steer_enable;
  logic       player_visible;
  logic       fuel_refill;
  logic       game_over;

  modport master (
    output frame_start, collisions, restart,
    input  state, lives, speed_zero, steer_enable, player_visible,
           fuel_refill, game_over
  );

  modport slave (
    input  frame_start, collisions, restart,
    output state, lives, speed_zero, steer_enable, player_visible,
           fuel_refill, game_over
  );
endinterface

// File: rtl/crash_sequencer_frame_timer.sv
// frame_timer: frame counter for the crash sequencer.
//   clk, resetN : clock, asynchronous active-low reset
//   clear       : synchronous clear (state entry / restart), beats frame_en
//   frame_en    : advance by one on this clk
//   terminal    : saturation value for the current state
//   count       : current frame count
//   done        : count has reached terminal
module frame_timer #(
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             clear,
  input  logic             frame_en,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  assign done = (count == terminal);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (frame_en && !done) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/crash_sequencer.sv
// crash_sequencer: player crash / respawn / game-over sequencing.
//   clk    : system clock
//   resetN : asynchronous active-low reset
//   bus    : crash_sequencer_if.slave (frame_start, collisions, restart in;
//            state, lives, speed_zero, steer_enable, player_visible,
//            fuel_refill, game_over out)
// Everything advances only on frame_start clocks; restart acts on any clk.
module crash_sequencer
  import crash_sequencer_pkg::*;
#(
  parameter int unsigned CRASH_FRAMES   = DEF_CRASH_FRAMES,
  parameter int unsigned RESPAWN_FRAMES = DEF_RESPAWN_FRAMES,
  parameter int unsigned BLINK_HALF     = DEF_BLINK_HALF,
  parameter int unsigned INIT_LIVES     = DEF_INIT_LIVES
) (
  input logic              clk,
  input logic              resetN,
  crash_sequencer_if.slave bus
);

  localparam int unsigned MAX_FRAMES =
    (CRASH_FRAMES > RESPAWN_FRAMES) ? CRASH_FRAMES : RESPAWN_FRAMES;
  localparam int unsigned CW        = $clog2(MAX_FRAMES + 1);
  localparam int unsigned BLINK_BIT = $clog2(BLINK_HALF);

  state_e        state_q, state_d;
  logic [1:0]    lives_q, lives_d;
  logic          fuel_hist_q;
  logic          fuel_refill_q;
  logic          fuel_edge;
  logic [CW-1:0] count;
  logic [CW-1:0] terminal;
  logic          done;
  logic          timer_clear;
  logic          speed_zero, steer_enable, player_visible, game_over;

  // Terminal is N-1: the Nth frame pulse in a timed state sees done and
  // leaves, so the state spans exactly N pulses after its entry edge.
  always_comb begin
    terminal = '1;
    unique case (state_q)
      ST_CRASH:   terminal = CW'(CRASH_FRAMES - 1);
      ST_RESPAWN: terminal = CW'(RESPAWN_FRAMES - 1);
      default:    terminal = '1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    if (bus.restart) begin
      state_d = ST_NORMAL;
      lives_d = 2'(INIT_LIVES);
    end else if (bus.frame_start) begin
      unique case (state_q)
        ST_NORMAL: begin
          if (bus.collisions[0]) begin
            state_d = ST_CRASH;
            if (lives_q != '0) lives_d = lives_q - 2'd1;
          end
        end
        ST_CRASH: begin
          if (done) state_d = (lives_q != '0) ? ST_RESPAWN : ST_GAME_OVER;
        end
        ST_RESPAWN: begin
          if (done) state_d = ST_NORMAL;
        end
        default: ;
      endcase
    end
  end

  // A crash in the same frame suppresses the refill.
  assign fuel_edge = bus.frame_start && (state_q == ST_NORMAL) &&
                     bus.collisions[1] && !fuel_hist_q && !bus.collisions[0];

  assign timer_clear = bus.restart || (state_d != state_q);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= ST_NORMAL;
      lives_q       <= 2'(INIT_LIVES);
      fuel_hist_q   <= 1'b0;
      fuel_refill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      if (bus.restart) begin
        fuel_hist_q   <= 1'b0;
        fuel_refill_q <= 1'b0;
      end else begin
        fuel_refill_q <= fuel_edge;
        if (bus.frame_start) fuel_hist_q <= bus.collisions[1];
      end
    end
  end

  frame_timer #(
    .WIDTH(CW)
  ) u_frame_timer (
    .clk     (clk),
    .resetN  (resetN),
    .clear   (timer_clear),
    .frame_en(bus.frame_start),
    .terminal(terminal),
    .count   (count),
    .done    (done)
  );

  always_comb begin
    speed_zero     = 1'b0;
    steer_enable   = 1'b1;
    player_visible = 1'b1;
    game_over      = 1'b0;
    unique case (state_q)
      ST_CRASH: begin
        speed_zero   = 1'b1;
        steer_enable = 1'b0;
      end
      ST_RESPAWN: begin
        // Visible while the blink bit of the frame count is clear.
        player_visible = ((count & (CW'(1) << BLINK_BIT)) == '0);
      end
      ST_GAME_OVER: begin
        speed_zero   = 1'b1;
        steer_enable = 1'b0;
        game_over    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.state          = state_q;
  assign bus.lives          = lives_q;
  assign bus.speed_zero     = speed_zero;
  assign bus.steer_enable   = steer_enable;
  assign bus.player_visible = player_visible;
  assign bus.fuel_refill    = fuel_refill_q;
  assign bus.game_over      = game_over;

endmodule

// File: tb/tb_crash_sequencer.sv
// Self-checking bench for crash_sequencer.
module tb_crash_sequencer;
  import crash_sequencer_pkg::*;

  localparam int unsigned CF    = 60;
  localparam int unsigned RF    = 90;
  localparam int unsigned BLINK = 4;

  typedef struct {
    string      tag;
    logic [8:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic resetN = 1'b1;
  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  crash_sequencer_if bus ();

  crash_sequencer #(
    .CRASH_FRAMES  (CF),
    .RESPAWN_FRAMES(RF),
    .BLINK_HALF    (BLINK),
    .INIT_LIVES    (3)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected output vector from the per-state output table.
  function automatic logic [8:0] expv(input logic [1:0] st, input logic [1:0] lv,
                                      input logic vis, input logic fuel);
    logic sz, go;
    sz = (st == S_CRASH) || (st == S_GAME_OVER);
    go = (st == S_GAME_OVER);
    return {st, lv, sz, ~sz, vis, fuel, go};
  endfunction

  function automatic logic [8:0] observed();
    return {bus.state, bus.lives, bus.speed_zero, bus.steer_enable,
            bus.player_visible, bus.fuel_refill, bus.game_over};
  endfunction

  function automatic logic blink_vis(input int unsigned k);
    return ((k / BLINK) % 2) == 0;
  endfunction

  task automatic tick(input logic f, input logic [1:0] c, input logic r);
    @(negedge clk);
    bus.frame_start = f;
    bus.collisions  = c;
    bus.restart     = r;
    @(posedge clk);
    #1;
    bus.frame_start = 1'b0;
    bus.restart     = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    bus.frame_start = 1'b0;
    bus.collisions  = 2'b00;
    bus.restart     = 1'b0;
    #2 resetN = 1'b0;
    sb.push_back('{tag: "reset_state", v: expv(S_NORMAL, 2'd3, 1'b1, 1'b0)});
    #1;
    e = sb.pop_front(); vectors++;
    if (observed() !== e.v) begin
      miscompares++;
      $display("FAIL %s: observed %b required %b", e.tag, observed(), e.v);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) resetN = 1'b1;
  endtask

  task automatic test_crash_cycle();
    exp_t e;
    sb.push_back('{tag: "crash_entry", v: expv(S_CRASH, 2'd2, 1'b1, 1'b0)});
    tick(1'b1, 2'b01, 1'b0);
    e = sb.pop_front(); vectors++;
    if (observed() !== e.v) begin
      miscompares++;
      $display("FAIL %s: observed %b required %b", e.tag, observed(), e.v);
    end
    tick(1'b0, 2'b00, 1'b0);
    for (int unsigned k = 1; k <= CF; k++) begin
      sb.push_back('{tag: $sformatf("crash_frame%0d", k),
                     v: expv((k < CF) ? S_CRASH : S_RESPAWN, 2'd2, 1'b1, 1'b0)});
      tick(1'b1, 2'b00, 1'b0);
      e = sb.pop_front(); vectors++;
      if (observed() !== e.v) begin
        miscompares++;
        $display("FAIL %s: observed %b required %b", e.tag, observed(), e.v);
      end
      tick(1'b0, 2'b00, 1'b0);
    end
    // Car hits during RESPAWN must be ignored; blink runs visible first.
    for (int unsigned k = 1; k <= RF; k++) begin
      sb.push_back('{tag: $sformatf("respawn_frame%0d", k),
                     v: (k < RF) ? expv(S_RESPAWN, 2'd2, blink_vis(k), 1'b0)
                                 : expv(S_NORMAL, 2'd2, 1'b1, 1'b0)});
      tick(1'b1, 2'b01, 1'b0);
      e = sb.pop_front(); vectors++;
      if (observed() !== e.v) begin
        miscompares++;
        $display("FAIL %s: observed %b required %b", e.tag, observed(), e.v);
      end
      tick(1'b0, 2'b00, 1'b0);
    end
  endtask

  task automatic test_fuel();
    exp_t e;
    logic [1:0] pat [7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10};
    logic       pls [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int unsigned i = 0; i < 7; i++) begin
      sb.push_back('{tag: $sformatf("fuel_frame%0d", i),
                     v: expv(S_NORMAL, 2'd2, 1'b1, pls[i])});
      tick(1'b1, pat[i], 1'b0);
      e = sb.pop_front(); vectors++;
      if (observed() !== e.v) begin
        miscompares++;
        $display("FAIL %s: observed %b required %b", e.tag, observed(), e.v);
      end
      sb.push_back('{tag: $sformatf("fuel_idle%0d", i),
                     v: expv(S_NORMAL, 2'd2, 1'b1, 1'b0)});
      tick(1'b0, pat[i], 1'b0);
      e = sb.pop_front(); vectors++;
      if (observed() !== e.v) begin
        miscompares++;
        $display("FAIL %s: observed %b required %b", e.tag, observed(), e.v);
      end
    end
  endtask

  task automatic test_both_bits();
    exp_t e;
    logic [1:0] pat [3] = '{2'b00, 2'b11, 2'b00};
    logic [8:0] ev  [3];
    ev[0] = expv(S_NORMAL, 2'd2, 1'b1, 1'b0);
    ev[1] = expv(S_CRASH, 2'd1, 1'b1, 1'b0);
    ev[2] = expv(S_CRASH, 2'd1, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 3; i++) begin
      sb.push_back('{tag: $sformatf("both_bits%0d", i), v: ev[i]});
      tick(1'b1, pat[i], 1'b0);
      e = sb.pop_front(); vectors++;
      if (observed() !== e.v) begin
        miscompares++;
        $display("FAIL %s: observed %b required %b", e.tag, observed(), e.v);
      end
      tick(1'b0, pat[i], 1'b0);
    end
  endtask

  task automatic test_restart_mid_crash();
    exp_t e;
    repeat (8) begin
      tick(1'b1, 2'b00, 1'b0);
      tick(1'b0, 2'b00, 1'b0);
    end
    sb.push_back('{tag: "restart_wins", v: expv(S_NORMAL, 2'd3, 1'b1, 1'b0)});
    tick(1'b1, 2'b11, 1'b1);
    e = sb.pop_front(); vectors++;
    if (observed() !== e.v) begin
      miscompares++;
      $display("FAIL %s: observed %b required %b", e.tag, observed(), e.v);
    end
    sb.push_back('{tag: "restart_idle", v: expv(S_NORMAL, 2'd3, 1'b1, 1'b0)});
    tick(1'b0, 2'b00, 1'b0);
    e = sb.pop_front(); vectors++;
    if (observed() !== e.v) begin
      miscompares++;
      $display("FAIL %s: observed %b required %b", e.tag, observed(), e.v);
    end
  endtask

  task automatic test_game_over();
    exp_t e;
    logic [1:0] junk [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
    for (int unsigned n = 1; n <= 3; n++) begin
      sb.push_back('{tag: $sformatf("go_crash%0d", n),
                     v: expv(S_CRASH, 2'(3 - n), 1'b1, 1'b0)});
      tick(1'b1, 2'b01, 1'b0);
      e = sb.pop_front(); vectors++;
      if (observed() !== e.v) begin
        miscompares++;
        $display("FAIL %s: observed %b required %b", e.tag, observed(), e.v);
      end
      tick(1'b0, 2'b00, 1'b0);
      for (int unsigned k = 1; k <= CF; k++) begin
        sb.push_back('{tag: $sformatf("go_crash%0d_frame%0d", n, k),
                       v: expv((k < CF) ? S_CRASH : ((n < 3) ? S_RESPAWN : S_GAME_OVER),
                               2'(3 - n), 1'b1, 1'b0)});
        tick(1'b1, 2'b00, 1'b0);
        e = sb.pop_front(); vectors++;
        if (observed() !== e.v) begin
          miscompares++;
          $display("FAIL %s: observed %b required %b", e.tag, observed(), e.v);
        end
        tick(1'b0, 2'b00, 1'b0);
      end
      if (n < 3) begin
        for (int unsigned k = 1; k <= RF; k++) begin
          sb.push_back('{tag: $sformatf("go_respawn%0d_frame%0d", n, k),
                         v: (k < RF) ? expv(S_RESPAWN, 2'(3 - n), blink_vis(k), 1'b0)
                                     : expv(S_NORMAL, 2'(3 - n), 1'b1, 1'b0)});
          tick(1'b1, 2'b00, 1'b0);
          e = sb.pop_front(); vectors++;
          if (observed() !== e.v) begin
            miscompares++;
            $display("FAIL %s: observed %b required %b", e.tag, observed(), e.v);
          end
          tick(1'b0, 2'b00, 1'b0);
        end
      end
    end
    for (int unsigned i = 0; i < 4; i++) begin
      sb.push_back('{tag: $sformatf("go_ignore%0d", i),
                     v: expv(S_GAME_OVER, 2'd0, 1'b1, 1'b0)});
      tick(1'b1, junk[i], 1'b0);
      e = sb.pop_front(); vectors++;
      if (observed() !== e.v) begin
        miscompares++;
        $display("FAIL %s: observed %b required %b", e.tag, observed(), e.v);
      end
      tick(1'b0, junk[i], 1'b0);
    end
    sb.push_back('{tag: "go_restart", v: expv(S_NORMAL, 2'd3, 1'b1, 1'b0)});
    tick(1'b0, 2'b00, 1'b1);
    e = sb.pop_front(); vectors++;
    if (observed() !== e.v) begin
      miscompares++;
      $display("FAIL %s: observed %b required %b", e.tag, observed(), e.v);
    end
  endtask

  task automatic test_reset_mid_respawn();
    exp_t e;
    tick(1'b1, 2'b01, 1'b0);
    tick(1'b0, 2'b00, 1'b0);
    repeat (CF) begin
      tick(1'b1, 2'b00, 1'b0);
      tick(1'b0, 2'b00, 1'b0);
    end
    // Fuel-can contact during RESPAWN loads the history with 1.
    for (int unsigned k = 1; k <= 5; k++) begin
      sb.push_back('{tag: $sformatf("mid_respawn%0d", k),
                     v: expv(S_RESPAWN, 2'd2, blink_vis(k), 1'b0)});
      tick(1'b1, 2'b10, 1'b0);
      e = sb.pop_front(); vectors++;
      if (observed() !== e.v) begin
        miscompares++;
        $display("FAIL %s: observed %b required %b", e.tag, observed(), e.v);
      end
      tick(1'b0, 2'b10, 1'b0);
    end
    sb.push_back('{tag: "async_reset", v: expv(S_NORMAL, 2'd3, 1'b1, 1'b0)});
    @(negedge clk) resetN = 1'b0;
    #1;
    e = sb.pop_front(); vectors++;
    if (observed() !== e.v) begin
      miscompares++;
      $display("FAIL %s: observed %b required %b", e.tag, observed(), e.v);
    end
    @(negedge clk) resetN = 1'b1;
    sb.push_back('{tag: "post_reset_idle", v: expv(S_NORMAL, 2'd3, 1'b1, 1'b0)});
    tick(1'b0, 2'b10, 1'b0);
    e = sb.pop_front(); vectors++;
    if (observed() !== e.v) begin
      miscompares++;
      $display("FAIL %s: observed %b required %b", e.tag, observed(), e.v);
    end
    // History was cleared by reset, so a held fuel contact is a fresh edge.
    sb.push_back('{tag: "post_reset_fuel", v: expv(S_NORMAL, 2'd3, 1'b1, 1'b1)});
    tick(1'b1, 2'b10, 1'b0);
    e = sb.pop_front(); vectors++;
    if (observed() !== e.v) begin
      miscompares++;
      $display("FAIL %s: observed %b required %b", e.tag, observed(), e.v);
    end
    sb.push_back('{tag: "post_reset_fuel_end", v: expv(S_NORMAL, 2'd3, 1'b1, 1'b0)});
    tick(1'b0, 2'b10, 1'b0);
    e = sb.pop_front(); vectors++;
    if (observed() !== e.v) begin
      miscompares++;
      $display("FAIL %s: observed %b required %b", e.tag, observed(), e.v);
    end
  endtask

  initial begin
    test_reset();
    test_crash_cycle();
    test_fuel();
    test_both_bits();
    test_restart_mid_crash();
    test_game_over();
    test_reset_mid_respawn();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: observed %0d left required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "timeout");
  end

endmodule
